periph_bridge: RTL and testbench
================================

# periph_bridge

Parametrised CPU-to-memory/peripheral bridge with wait-state handshaking. It sits between the CPU data port, the DRAM and up to N_PERIPH MMIO slaves. DRAM accesses complete with zero wait states. Peripheral accesses run through a request/ready FSM with a timeout, registered read data, error signalling and a sticky fault capture register.

## Interface
- N_PERIPH, 8, number of peripheral slots (1..16)
- PERI_PAGE, 20'hFFFFF, addr[31:12] value selecting the peripheral page; any other value is DRAM
- SLOT_LSB, 4, slot index = addr[11:SLOT_LSB]; slots ≥ N_PERIPH are unmapped
- TIMEOUT, 16, maximum WAIT cycles before abort (≥1)
- DEAD_WORD, 32'hDEAD_FFFF, read data returned on unmapped/timeout
- clk_from_cpu  in  1  single clock for all logic
- rst_from_cpu  in  1  synchronous, active-high reset
- req_from_cpu  in  1  access request; addr/we/wdata valid while high
- addr_from_cpu  in  32  byte address
- we_from_cpu  in  1  1 = write
- wdata_from_cpu  in  32  write data
- rdata_to_cpu  out  32  read data
- ready_to_cpu  out  1  access complete this cycle
- err_to_cpu  out  1  one-cycle pulse with ready_to_cpu on unmapped/timeout
- clk_to_dram  out  1  = clk_from_cpu
- addr_to_dram  out  32  = addr_from_cpu
- we_to_dram  out  1  DRAM write strobe
- wdata_to_dram  out  32  = wdata_from_cpu
- rdata_from_dram  in  32  DRAM read data (combinational)
- sel_to_periph  out  N_PERIPH  one-hot slot select
- we_to_periph  out  1  latched write flag
- addr_to_periph  out  32  latched address
- wdata_to_periph  out  32  latched write data
- rdata_from_periph  in  32*N_PERIPH  slot k data at [32k+31:32k]
- ready_from_periph  in  N_PERIPH  per-slot completion
- fault_clr  in  1  clears the fault register
- fault_valid  out  1  sticky fault flag
- fault_addr  out  32  address of the first uncleared fault
- fault_is_timeout  out  1  1 = timeout, 0 = unmapped

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, req, DRAM address:
  - ready_to_cpu=1 combinationally; rdata_to_cpu=rdata_from_dram.
  - we_to_dram=req&we; state stays IDLE.
- IDLE, req, mapped slot: latch addr/we/wdata/slot, clear the counter, go to WAIT.
- IDLE, req, unmapped slot:
  - Load DEAD_WORD into the response register, set the error flag, go to RESP.
  - No sel is asserted and the write is discarded.
- WAIT:
  - sel_to_periph[slot]=1 and we_to_periph=latched we; the counter increments each cycle.
  - The transaction completes on the edge where ready_from_periph[slot]=1: the peripheral commits a write, the bridge captures a read into the response register. Then go to RESP.
  - If the counter reaches TIMEOUT-1 with no ready, load DEAD_WORD, set the error flag and go to RESP.
  - If ready arrives on the timeout cycle, ready wins: normal completion, no fault.
- RESP:
  - ready_to_cpu=1, rdata_to_cpu=response register, err_to_cpu=error flag.
  - Unconditionally return to IDLE.
  - The CPU must drop req or present a new access in the next cycle.
- Not-ready states: in WAIT, and in IDLE with no req, ready_to_cpu=0 and rdata_to_cpu=response register. we_to_dram=0 outside IDLE.
- Fault register:
  - On an unmapped or timeout abort with fault_valid=0, capture addr and type and set fault_valid. Later faults do not overwrite.
  - fault_clr clears it. A new fault in the same cycle as fault_clr is captured (set wins).
- Reset mid-transaction: next state IDLE, sel drops after the reset edge, no response is issued, the fault register clears.

## Timing
- Reset values: state IDLE; sel_to_periph=0; we_to_periph=0; addr/wdata_to_periph=0; response register=0; err_to_cpu=0; ready_to_cpu=0 (unless a DRAM req is present in IDLE); fault_valid=0; fault_addr=0; fault_is_timeout=0.
- DRAM access: 0 wait states, completes in the accept cycle T.
- Mapped peripheral accepted at T:
  - sel is asserted from T+1.
  - If the first ready is in cycle T+k (k≥1), ready_to_cpu is high at T+k+1. Minimum latency is 2 cycles.
- Unmapped: ready_to_cpu and err_to_cpu at T+1.
- Timeout: WAIT spans T+1..T+TIMEOUT; ready_to_cpu and err_to_cpu at T+TIMEOUT+1.
- Counter width: clog2(TIMEOUT+1) bits; it does not wrap because WAIT exits at TIMEOUT-1.
- Only the selected slot's ready and rdata are observed; other slots' ready is ignored.

## Test plan
- DRAM: write 0x0000_0100 ← 0xCAFE_0001, then read it back → ready_to_cpu in the same cycle each time, we_to_dram high for one cycle, read returns 0xCAFE_0001, sel_to_periph stays 0.
- Slot 2 read at 0xFFFF_F020, peripheral ready at T+3 with 0x1234_5678 → sel_to_periph=8'b0000_0100 for T+1..T+3, ready_to_cpu at T+4 with rdata 0x1234_5678, err_to_cpu=0.
- Slot 5 read at 0xFFFF_F050, never ready, TIMEOUT=16 → ready_to_cpu and err_to_cpu at T+17, rdata 0xDEAD_FFFF, fault_valid=1, fault_addr=0xFFFF_F050, fault_is_timeout=1.
- Write to unmapped 0xFFFF_F0A0 (slot 10, N_PERIPH=8) → ready_to_cpu and err_to_cpu at T+1, no sel asserted. With the earlier fault still set, fault_addr stays 0xFFFF_F050. After fault_clr, a repeat of this write yields fault_addr=0xFFFF_F0A0 and fault_is_timeout=0.
- Slot 1 write, ready first asserted at T+16 (the timeout cycle) → normal completion at T+17, err_to_cpu=0, fault unchanged. Second case: fault_clr in the same cycle as a new unmapped abort → fault_valid=1.
- rst_from_cpu pulsed at T+3 of a WAIT → sel_to_periph=0 at T+4, no ready_to_cpu pulse, state IDLE. A following DRAM read completes in its accept cycle.

Source files
------------

// File: rtl/periph_bridge.sv
// CPU data-port bridge: zero-wait DRAM path plus a request/ready FSM with timeout
// for MMIO slots, a registered response and a sticky first-fault capture register.
module periph_bridge #(
  parameter int          N_PERIPH  = 8,
  parameter logic [19:0] PERI_PAGE = 20'hFFFFF,
  parameter int          SLOT_LSB  = 4,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] DEAD_WORD = 32'hDEAD_FFFF
) (
  input  logic                     clk_from_cpu,
  input  logic                     rst_from_cpu,
  input  logic                     req_from_cpu,
  input  logic [31:0]              addr_from_cpu,
  input  logic                     we_from_cpu,
  input  logic [31:0]              wdata_from_cpu,
  output logic [31:0]              rdata_to_cpu,
  output logic                     ready_to_cpu,
  output logic                     err_to_cpu,
  output logic                     clk_to_dram,
  output logic [31:0]              addr_to_dram,
  output logic                     we_to_dram,
  output logic [31:0]              wdata_to_dram,
  input  logic [31:0]              rdata_from_dram,
  output logic [N_PERIPH-1:0]      sel_to_periph,
  output logic                     we_to_periph,
  output logic [31:0]              addr_to_periph,
  output logic [31:0]              wdata_to_periph,
  input  logic [32*N_PERIPH-1:0]   rdata_from_periph,
  input  logic [N_PERIPH-1:0]      ready_from_periph,
  input  logic                     fault_clr,
  output logic                     fault_valid,
  output logic [31:0]              fault_addr,
  output logic                     fault_is_timeout
);

  localparam int SIW  = 12 - SLOT_LSB;
  localparam int SIW1 = SIW + 1;
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [SIW:0]  NP       = SIW1'(N_PERIPH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [N_PERIPH-1:0] sel_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         resp_q;
  logic                err_q;
  logic                fault_valid_q;
  logic [31:0]         fault_addr_q;
  logic                fault_to_q;

  logic                is_peri;
  logic                mapped;
  logic                dram_acc;
  logic                unmapped_acc;
  logic                peri_rdy;
  logic                wait_to;
  logic                abort;
  logic [31:0]         abort_addr;
  logic [SIW-1:0]      slot_idx;
  logic [N_PERIPH-1:0] slot_dec;
  logic [31:0]         peri_rdata;

  assign is_peri      = (addr_from_cpu[31:12] == PERI_PAGE);
  assign slot_idx     = addr_from_cpu[11:SLOT_LSB];
  assign mapped       = ({1'b0, slot_idx} < NP);
  assign dram_acc     = (state_q == IDLE) && req_from_cpu && !is_peri;
  assign unmapped_acc = (state_q == IDLE) && req_from_cpu && is_peri && !mapped;
  // sel_q is one-hot in WAIT, so masking with it observes only the selected slot.
  assign peri_rdy     = |(ready_from_periph & sel_q);
  assign wait_to      = (state_q == WAIT) && !peri_rdy && (cnt_q == CNT_LAST);
  assign abort        = unmapped_acc || wait_to;
  assign abort_addr   = (state_q == WAIT) ? addr_q : addr_from_cpu;

  always_comb begin
    slot_dec   = '0;
    peri_rdata = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      slot_dec[k] = (slot_idx == SIW'(k));
      if (sel_q[k]) peri_rdata = peri_rdata | rdata_from_periph[32*k +: 32];
    end
  end

  always_ff @(posedge clk_from_cpu) begin
    if (rst_from_cpu) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_q        <= '0;
      err_q         <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_from_cpu && is_peri) begin
            if (mapped) begin
              addr_q  <= addr_from_cpu;
              wdata_q <= wdata_from_cpu;
              we_q    <= we_from_cpu;
              sel_q   <= slot_dec;
              cnt_q   <= '0;
              state_q <= WAIT;
            end else begin
              resp_q  <= DEAD_WORD;
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          // A ready arriving on the last counted cycle still completes normally.
          if (peri_rdy) begin
            if (!we_q) resp_q <= peri_rdata;
            err_q   <= 1'b0;
            sel_q   <= '0;
            state_q <= RESP;
          end else if (wait_to) begin
            resp_q  <= DEAD_WORD;
            err_q   <= 1'b1;
            sel_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (fault_clr) begin
        fault_valid_q <= 1'b0;
        fault_addr_q  <= '0;
        fault_to_q    <= 1'b0;
      end
      // Only the first fault since the last clear is kept; a clear in the same cycle loses.
      if (abort && (!fault_valid_q || fault_clr)) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= abort_addr;
        fault_to_q    <= wait_to;
      end
    end
  end

  assign clk_to_dram      = clk_from_cpu;
  assign addr_to_dram     = addr_from_cpu;
  assign wdata_to_dram    = wdata_from_cpu;
  assign we_to_dram       = dram_acc && we_from_cpu;
  assign sel_to_periph    = sel_q;
  assign we_to_periph     = we_q;
  assign addr_to_periph   = addr_q;
  assign wdata_to_periph  = wdata_q;
  assign ready_to_cpu     = dram_acc || (state_q == RESP);
  assign rdata_to_cpu     = dram_acc ? rdata_from_dram : resp_q;
  assign err_to_cpu       = (state_q == RESP) && err_q;
  assign fault_valid      = fault_valid_q;
  assign fault_addr       = fault_addr_q;
  assign fault_is_timeout = fault_to_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge: per-cycle expectations are built from transaction
// latencies and pushed to a queue; one negedge process compares every output.
module tb_periph_bridge;

  localparam int          NP      = 8;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] DEAD    = 32'hDEAD_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata_to_cpu;
  logic          ready_to_cpu;
  logic          err_to_cpu;
  logic          clk_to_dram;
  logic [31:0]   addr_to_dram;
  logic          we_to_dram;
  logic [31:0]   wdata_to_dram;
  logic [31:0]   rdata_from_dram;
  logic [NP-1:0] sel_to_periph;
  logic          we_to_periph;
  logic [31:0]   addr_to_periph;
  logic [31:0]   wdata_to_periph;
  logic [32*NP-1:0] rdata_from_periph;
  logic [NP-1:0] ready_from_periph;
  logic          fault_clr;
  logic          fault_valid;
  logic [31:0]   fault_addr;
  logic          fault_is_timeout;

  periph_bridge #(.N_PERIPH(NP), .TIMEOUT(TIMEOUT)) dut (
    .clk_from_cpu(clk), .rst_from_cpu(rst), .req_from_cpu(req),
    .addr_from_cpu(addr), .we_from_cpu(we), .wdata_from_cpu(wdata),
    .rdata_to_cpu(rdata_to_cpu), .ready_to_cpu(ready_to_cpu), .err_to_cpu(err_to_cpu),
    .clk_to_dram(clk_to_dram), .addr_to_dram(addr_to_dram), .we_to_dram(we_to_dram),
    .wdata_to_dram(wdata_to_dram), .rdata_from_dram(rdata_from_dram),
    .sel_to_periph(sel_to_periph), .we_to_periph(we_to_periph),
    .addr_to_periph(addr_to_periph), .wdata_to_periph(wdata_to_periph),
    .rdata_from_periph(rdata_from_periph), .ready_from_periph(ready_from_periph),
    .fault_clr(fault_clr), .fault_valid(fault_valid), .fault_addr(fault_addr),
    .fault_is_timeout(fault_is_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ready;
    logic          err;
    logic          chk_rd;
    logic [31:0]   rdata;
    logic [NP-1:0] sel;
    logic          we_dram;
    logic          fv;
    logic [31:0]   fa;
    logic          fto;
    logic          we_p;
    logic [31:0]   addr_p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Spec-level model state: response register, fault register, DRAM contents.
  logic [31:0] m_resp;
  logic        m_fv;
  logic [31:0] m_fa;
  logic        m_fto;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready_to_cpu", 32'(ready_to_cpu), 32'(e.ready));
      chk("err_to_cpu", 32'(err_to_cpu), 32'(e.err));
      chk("sel_to_periph", 32'(sel_to_periph), 32'(e.sel));
      chk("we_to_dram", 32'(we_to_dram), 32'(e.we_dram));
      chk("fault_valid", 32'(fault_valid), 32'(e.fv));
      chk("fault_addr", fault_addr, e.fa);
      chk("fault_is_timeout", 32'(fault_is_timeout), 32'(e.fto));
      if (e.chk_rd) chk("rdata_to_cpu", rdata_to_cpu, e.rdata);
      if (e.sel != '0) begin
        chk("we_to_periph", 32'(we_to_periph), 32'(e.we_p));
        chk("addr_to_periph", addr_to_periph, e.addr_p);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e.ready = 1'b0; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = '0; e.sel = '0;
    e.we_dram = 1'b0; e.fv = m_fv; e.fa = m_fa; e.fto = m_fto;
    e.we_p = 1'b0; e.addr_p = '0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    m_fv = 1'b0; m_fa = '0; m_fto = 1'b0;
  endtask

  task automatic m_fault(input logic [31:0] a, input logic to);
    if (!m_fv) begin
      m_fv = 1'b1; m_fa = a; m_fto = to;
    end
  endtask

  task automatic idle(input int n, input bit clr);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      req = 1'b0; we = 1'b0; ready_from_periph = '0;
      fault_clr = clr && (i == 0);
      e = base(); e.chk_rd = 1'b1; e.rdata = m_resp;
      step(e);
      if (clr && i == 0) m_clear();
    end
    fault_clr = 1'b0;
  endtask

  task automatic dram(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    logic [31:0] rd;
    rd = mem.exists(a) ? mem[a] : 32'h0;
    req = 1'b1; addr = a; we = w; wdata = d; rdata_from_dram = rd;
    #1;
    chk("addr_to_dram", addr_to_dram, a);
    chk("wdata_to_dram", wdata_to_dram, d);
    e = base(); e.ready = 1'b1; e.we_dram = w; e.chk_rd = !w; e.rdata = rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (w) mem[a] = d;
  endtask

  // k = cycle offset of the first peripheral ready (0 = never); clr pulses fault_clr at accept.
  task automatic periph(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] rd, input int k, input bit other_rdy, input bit clr);
    exp_t e;
    int slot, jd;
    bit to;
    logic [NP-1:0] oh, other;
    slot = int'(a[11:4]);
    req = 1'b1; addr = a; we = w; wdata = d; ready_from_periph = '0; fault_clr = clr;
    e = base();
    step(e);
    fault_clr = 1'b0;
    if (slot >= NP) begin
      if (clr) m_clear();
      m_resp = DEAD;
      m_fault(a, 1'b0);
      e = base(); e.ready = 1'b1; e.err = 1'b1; e.chk_rd = 1'b1; e.rdata = m_resp;
      step(e);
    end else begin
      if (clr) m_clear();
      oh = '0; oh[slot] = 1'b1;
      other = '0; other[(slot + 1) % NP] = 1'b1;
      for (int s = 0; s < NP; s++)
        rdata_from_periph[32*s +: 32] = (s == slot) ? rd : ~rd;
      to = (k == 0) || (k > TIMEOUT);
      jd = to ? TIMEOUT : k;
      for (int j = 1; j <= jd; j++) begin
        ready_from_periph = (!to && j >= k) ? oh : '0;
        if (other_rdy) ready_from_periph = ready_from_periph | other;
        e = base(); e.sel = oh; e.we_p = w; e.addr_p = a;
        step(e);
      end
      ready_from_periph = '0;
      if (to) begin
        m_resp = DEAD;
        m_fault(a, 1'b1);
      end else if (!w) begin
        m_resp = rd;
      end
      e = base(); e.ready = 1'b1; e.err = to; e.chk_rd = to || !w; e.rdata = m_resp;
      step(e);
    end
  endtask

  initial begin
    exp_t e;
    logic [NP-1:0] oh3;
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; wdata = '0; rdata_from_dram = '0;
    rdata_from_periph = '0; ready_from_periph = '0; fault_clr = 1'b0;
    m_resp = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 0);
    chk("pin_reset_rdata", rdata_to_cpu, 32'h0);
    chk("pin_reset_addr_to_periph", addr_to_periph, 32'h0);

    dram(32'h0000_0100, 1'b1, 32'hCAFE_0001);
    idle(1, 0);
    dram(32'h0000_0100, 1'b0, 32'h0);
    idle(1, 0);

    periph(32'hFFFF_F020, 1'b0, 32'h0, 32'h1234_5678, 3, 1, 0);
    idle(1, 0);
    chk("pin_slot2_rdata", rdata_to_cpu, 32'h1234_5678);

    periph(32'hFFFF_F070, 1'b0, 32'h0, 32'h0BAD_F00D, 1, 0, 0);
    idle(1, 0);

    periph(32'hFFFF_F050, 1'b0, 32'h0, 32'hAAAA_5555, 0, 1, 0);
    idle(1, 0);
    chk("pin_to_fault_valid", 32'(fault_valid), 32'd1);
    chk("pin_to_fault_addr", fault_addr, 32'hFFFF_F050);
    chk("pin_to_fault_type", 32'(fault_is_timeout), 32'd1);
    chk("pin_to_rdata", rdata_to_cpu, 32'hDEAD_FFFF);

    periph(32'hFFFF_F0A0, 1'b1, 32'h55, 32'h0, 0, 0, 0);
    idle(1, 0);
    chk("pin_sticky_fault_addr", fault_addr, 32'hFFFF_F050);
    idle(1, 1);
    chk("pin_clr_fault_valid", 32'(fault_valid), 32'd0);
    periph(32'hFFFF_F0A0, 1'b1, 32'h55, 32'h0, 0, 0, 0);
    idle(1, 0);
    chk("pin_unmapped_fault_addr", fault_addr, 32'hFFFF_F0A0);
    chk("pin_unmapped_fault_type", 32'(fault_is_timeout), 32'd0);

    periph(32'hFFFF_F080, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    idle(1, 0);
    periph(32'hFFFF_F010, 1'b1, 32'h7777_0001, 32'h0, TIMEOUT, 0, 0);
    idle(1, 0);
    chk("pin_edge_fault_addr", fault_addr, 32'hFFFF_F0A0);

    periph(32'hFFFF_F0B0, 1'b0, 32'h0, 32'h0, 0, 0, 1);
    idle(1, 0);
    chk("pin_setwins_valid", 32'(fault_valid), 32'd1);
    chk("pin_setwins_addr", fault_addr, 32'hFFFF_F0B0);

    // Reset pulsed on the third WAIT cycle of a slot-3 read.
    oh3 = '0; oh3[3] = 1'b1;
    req = 1'b1; addr = 32'hFFFF_F030; we = 1'b0; ready_from_periph = '0;
    e = base();
    step(e);
    for (int j = 1; j <= 3; j++) begin
      rst = (j == 3);
      e = base(); e.sel = oh3; e.we_p = 1'b0; e.addr_p = 32'hFFFF_F030;
      step(e);
    end
    rst = 1'b0;
    m_resp = '0;
    m_clear();
    idle(2, 0);
    chk("pin_rst_fault_valid", 32'(fault_valid), 32'd0);
    dram(32'h0000_0100, 1'b0, 32'h0);
    idle(1, 0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
